// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM state type and parameter derivations for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } scan_state_e;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int dwell_max(input int clk_rate, input int scan_rate);
    return clk_rate / scan_rate;
  endfunction

endpackage

// File: rtl/keypad_dwell_timer.sv
// rtl/keypad_dwell_timer.sv - per-row dwell counter with a one-cycle sample strobe on its last count
module keypad_dwell_timer
  import keypad_pkg::*;
#(
  parameter int ClkRate  = 10_000_000,
  parameter int ScanRate = 1_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic sample_o
);

  localparam int DwellMax = dwell_max(ClkRate, ScanRate);
  localparam int CntW     = $clog2(DwellMax);
  localparam logic [CntW-1:0] CntLast = CntW'(DwellMax - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart_i || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_o = (cnt_q == CntLast);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - row-scanning matrix keypad controller with press/release debounce
// and a valid/ready key-code event output.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ClkRate     = 10_000_000,
  parameter int ScanRate    = 1_000,
  parameter int Rows        = 4,
  parameter int Cols        = 4,
  parameter int StableScans = 4,
  localparam int CodeW      = code_width(Rows, Cols)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Cols-1:0]  col_i,
  output logic [Rows-1:0]  row_o,
  output logic             key_valid_o,
  output logic [CodeW-1:0] key_code_o,
  input  logic             key_ready_i,
  output logic             key_held_o,
  output logic             overflow_o
);

  localparam int RowW  = $clog2(Rows);
  localparam int ColW  = $clog2(Cols);
  localparam int StabW = $clog2(StableScans + 1);

  logic [Cols-1:0]  col_meta_q, col_meta_d;
  logic [Cols-1:0]  col_sync_q, col_sync_d;
  logic [RowW-1:0]  row_idx_q, row_idx_d;
  logic [RowW-1:0]  cand_row_q, cand_row_d;
  logic [ColW-1:0]  cand_col_q, cand_col_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [StabW-1:0] rel_q, rel_d;
  scan_state_e      state_q, state_d;
  logic             key_valid_q, key_valid_d;
  logic [CodeW-1:0] key_code_q, key_code_d;
  logic             overflow_q, overflow_d;

  logic            sample;
  logic            advance;
  logic            issue;
  logic            accept;
  logic            hit;
  logic [ColW-1:0] col_idx;

  // Row advance is the only thing that moves row_o, so it also realigns the dwell.
  keypad_dwell_timer #(
    .ClkRate (ClkRate),
    .ScanRate(ScanRate)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .restart_i(advance),
    .sample_o (sample)
  );

  always_comb begin
    col_meta_d = col_i;
    col_sync_d = col_meta_q;
    hit        = ~&col_sync_q;
    col_idx    = '0;
    for (int c = Cols - 1; c >= 0; c--) begin
      if (!col_sync_q[c]) begin
        col_idx = ColW'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    stab_d     = stab_q;
    rel_d      = rel_q;
    advance    = 1'b0;
    issue      = 1'b0;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            cand_row_d = row_idx_q;
            cand_col_d = col_idx;
            stab_d     = StabW'(1);
            state_d    = CONFIRM;
          end else begin
            advance = 1'b1;
          end
        end
        CONFIRM: begin
          if (hit && (col_idx == cand_col_q)) begin
            stab_d = stab_q + StabW'(1);
            if (stab_q == StabW'(StableScans - 1)) begin
              stab_d  = '0;
              state_d = HELD;
              issue   = 1'b1;
            end
          end else begin
            stab_d  = '0;
            state_d = SCAN;
            advance = 1'b1;
          end
        end
        HELD: begin
          // Only the confirmed column matters here; other keys on this row are ignored.
          if (col_sync_q[cand_col_q]) begin
            rel_d = rel_q + StabW'(1);
            if (rel_q == StabW'(StableScans - 1)) begin
              rel_d   = '0;
              state_d = SCAN;
              advance = 1'b1;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (advance) begin
      row_idx_d = (row_idx_q == RowW'(Rows - 1)) ? '0 : row_idx_q + RowW'(1);
    end
  end

  assign accept = key_valid_q && key_ready_i;

  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = 1'b0;
    if (accept) begin
      key_valid_d = 1'b0;
    end
    if (issue) begin
      if (!key_valid_q || accept) begin
        key_valid_d = 1'b1;
        key_code_d  = CodeW'(int'(cand_row_q) * Cols + int'(cand_col_q));
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q  <= '1;
      col_sync_q  <= '1;
      row_idx_q   <= '0;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      stab_q      <= '0;
      rel_q       <= '0;
      state_q     <= SCAN;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_sync_q  <= col_sync_d;
      row_idx_q   <= row_idx_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      stab_q      <= stab_d;
      rel_q       <= rel_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign row_o       = ~(Rows'(1) << row_idx_q);
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_held_o  = (state_q == HELD);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl: directed tables,
// hand sequences and a randomized run against a sample-level keypad model.
module tb_keypad_scan_ctrl;

  localparam int Rows        = 4;
  localparam int Cols        = 4;
  localparam int StableScans = 4;
  localparam int Dwell       = 10;
  localparam int M_SCAN      = 0;
  localparam int M_CONF      = 1;
  localparam int M_HELD      = 2;

  typedef struct {
    logic [15:0] first;
    logic [15:0] second;
    int          n_ev;
    int          code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_i;
  logic [3:0]  row_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        key_ready_i = 1'b1;
  logic        key_held_o;
  logic        overflow_o;
  logic [15:0] key_mask = '0;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;
  int ovf_count = 0;
  int last_code = -1;
  int m_row, m_mode, m_key, m_cnt;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ClkRate    (1000),
    .ScanRate   (100),
    .Rows       (Rows),
    .Cols       (Cols),
    .StableScans(StableScans)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_i      (col_i),
    .row_o      (row_o),
    .key_valid_o(key_valid_o),
    .key_code_o (key_code_o),
    .key_ready_i(key_ready_i),
    .key_held_o (key_held_o),
    .overflow_o (overflow_o)
  );

  // Passive switch matrix: a column is pulled low only through a pressed key on the driven row.
  always_comb begin
    col_i = '1;
    for (int r = 0; r < Rows; r++) begin
      for (int c = 0; c < Cols; c++) begin
        if (!row_o[r] && key_mask[r*Cols+c]) col_i[c] = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (key_valid_o && key_ready_i) begin
        ev_count++;
        last_code = int'(key_code_o);
      end
      if (overflow_o) ovf_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic dwell(input int n);
    repeat (n * Dwell) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_row", row_o, 4'hE);
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_code", key_code_o, 4'h0);
    check("rst_held", key_held_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    tick();
    rst = 1'b0;
    ev_count = 0;
    ovf_count = 0;
    last_code = -1;
    m_row = 0;
    m_mode = M_SCAN;
    m_key = 0;
    m_cnt = 0;
  endtask

  // One scan sample in terms of keys: which key on the current row is seen, and how long it has lasted.
  task automatic model_sample(output bit issue, output int code);
    int seen = -1;
    issue = 1'b0;
    code = 0;
    for (int c = Cols - 1; c >= 0; c--) begin
      if (key_mask[m_row*Cols+c]) seen = c;
    end
    case (m_mode)
      M_SCAN: begin
        if (seen < 0) m_row = (m_row + 1) % Rows;
        else begin
          m_key = m_row * Cols + seen;
          m_cnt = 1;
          m_mode = M_CONF;
        end
      end
      M_CONF: begin
        if (seen == m_key % Cols) begin
          m_cnt++;
          if (m_cnt == StableScans) begin
            m_mode = M_HELD;
            m_cnt = 0;
            issue = 1'b1;
            code = m_key;
          end
        end else begin
          m_mode = M_SCAN;
          m_row = (m_row + 1) % Rows;
        end
      end
      default: begin
        if (key_mask[m_key]) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == StableScans) begin
            m_cnt = 0;
            m_mode = M_SCAN;
            m_row = (m_row + 1) % Rows;
          end
        end
      end
    endcase
  endtask

  initial begin
    vec_t       vecs[7];
    logic [3:0] exp_row;
    bit         iss;
    int         code;

    vecs[0] = '{16'h0000, 16'h0000, 0, -1};
    vecs[1] = '{16'h0200, 16'h0200, 1, 9};
    vecs[2] = '{16'h0005, 16'h8005, 1, 0};
    vecs[3] = '{16'h8000, 16'h0000, 1, 15};
    vecs[4] = '{16'h0060, 16'h0060, 1, 5};
    vecs[5] = '{16'h1008, 16'h1008, 1, 3};
    vecs[6] = '{16'h0200, 16'h0400, 2, 10};

    // Idle scan: ten-cycle dwell per row, rows walk 0..3.
    key_mask = '0;
    do_reset();
    for (int t = 0; t < 100; t++) begin
      exp_row = ~(4'b0001 << ((t / Dwell) % Rows));
      check("idle_row", row_o, exp_row);
      tick();
    end
    check("idle_events", ev_count, 0);

    // Single key row 2 col 1: latency, hold, and release debounce.
    do_reset();
    key_mask = 16'h0200;
    dwell(5);
    check("k9_early_valid", key_valid_o, 1'b0);
    check("k9_early_held", key_held_o, 1'b0);
    dwell(1);
    check("k9_valid", key_valid_o, 1'b1);
    check("k9_code", key_code_o, 4'd9);
    check("k9_held", key_held_o, 1'b1);
    check("k9_row", row_o, 4'hB);
    dwell(14);
    check("k9_events", ev_count, 1);
    check("k9_held_long", key_held_o, 1'b1);
    key_mask = '0;
    dwell(3);
    check("k9_held_rel3", key_held_o, 1'b1);
    dwell(1);
    check("k9_held_rel4", key_held_o, 1'b0);
    check("k9_row_after", row_o, 4'h7);
    check("k9_events_after", ev_count, 1);

    // Bouncing key row 1 col 3, then stable.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      if (t % 7 == 0) key_mask[7] = ~key_mask[7];
      tick();
    end
    check("bounce_events", ev_count, 0);
    key_mask = 16'h0080;
    dwell(12);
    check("bounce_stable_events", ev_count, 1);
    check("bounce_code", last_code, 7);
    check("bounce_held", key_held_o, 1'b1);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      key_mask = vecs[i].first;
      dwell(12);
      key_mask = vecs[i].second;
      dwell(12);
      key_mask = '0;
      dwell(12);
      check("vec_events", ev_count, vecs[i].n_ev);
      if (vecs[i].n_ev > 0) check("vec_code", last_code, vecs[i].code);
      check("vec_held", key_held_o, 1'b0);
      check("vec_ovf", ovf_count, 0);
    end

    // Second press while the first event is still pending is dropped.
    do_reset();
    key_ready_i = 1'b0;
    key_mask = 16'h0020;
    dwell(8);
    check("ovf_first_valid", key_valid_o, 1'b1);
    check("ovf_first_code", key_code_o, 4'd5);
    key_mask = '0;
    dwell(8);
    key_mask = 16'h0400;
    dwell(12);
    check("ovf_pulses", ovf_count, 1);
    check("ovf_code_kept", key_code_o, 4'd5);
    check("ovf_valid_kept", key_valid_o, 1'b1);
    check("ovf_no_accept", ev_count, 0);
    check("ovf_held2", key_held_o, 1'b1);
    key_ready_i = 1'b1;
    tick();
    check("ovf_accept", ev_count, 1);
    check("ovf_accept_code", last_code, 5);
    check("ovf_valid_clear", key_valid_o, 1'b0);

    // Asynchronous reset while held with an event pending.
    do_reset();
    key_ready_i = 1'b0;
    key_mask = 16'h2000;
    dwell(8);
    check("arst_pre_held", key_held_o, 1'b1);
    check("arst_pre_valid", key_valid_o, 1'b1);
    check("arst_pre_row", row_o, 4'h7);
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("arst_row", row_o, 4'hE);
    check("arst_valid", key_valid_o, 1'b0);
    check("arst_code", key_code_o, 4'h0);
    check("arst_held", key_held_o, 1'b0);
    check("arst_ovf", overflow_o, 1'b0);
    key_ready_i = 1'b1;
    key_mask = '0;

    // Randomized key episodes against the model, checked at every sample.
    do_reset();
    for (int ep = 0; ep < 40; ep++) begin
      int sel;
      int dur;
      sel = $urandom_range(0, 9);
      if (sel < 3) key_mask = '0;
      else if (sel < 7) key_mask = 16'(1) << $urandom_range(0, 15);
      else key_mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      dur = $urandom_range(1, 10);
      for (int d = 0; d < dur; d++) begin
        dwell(1);
        model_sample(iss, code);
        exp_row = ~(4'b0001 << m_row);
        check("rand_row", row_o, exp_row);
        check("rand_held", key_held_o, (m_mode == M_HELD));
        check("rand_valid", key_valid_o, iss);
        if (iss) check("rand_code", key_code_o, code);
      end
    end
    check("rand_ovf", ovf_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
